// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: register scoreboard and write-back arbiter.
// Tracks in-flight destination registers (busy vector), stalls hazardous
// issues, arbitrates ALU/LSU write-back round-robin, and drives the
// register-file write port with one cycle of latency.
// Optional feature: define WB_ERR_CHECK_EN to enable the sticky WbError
// check (write-back to a register that is not marked busy).
module regfile_wb_scheduler #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // issue side
  input  logic            IssueValid,
  input  logic [4:0]      IssueRs1,
  input  logic [4:0]      IssueRs2,
  input  logic [4:0]      IssueRd,
  output logic            IssueStall,
  // ALU write-back channel
  input  logic            AluValid,
  input  logic [4:0]      AluRd,
  input  logic [XLEN-1:0] AluData,
  output logic            AluReady,
  // LSU write-back channel
  input  logic            LsuValid,
  input  logic [4:0]      LsuRd,
  input  logic [XLEN-1:0] LsuData,
  output logic            LsuReady,
  // control
  input  logic            Flush,
  // register-file write port
  output logic            RegWrite,
  output logic [4:0]      WriteAddr,
  output logic [XLEN-1:0] WriteData,
  // status
  output logic [5:0]      PendingCount,
  output logic            WbError
);

  // Round-robin priority pointer: which source wins when both request.
  typedef enum logic {PTR_ALU = 1'b0, PTR_LSU = 1'b1} ptr_e;

  logic [31:0]     busy_q, busy_d;
  ptr_e            ptr_q, ptr_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      write_addr_q, write_addr_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [5:0]      pending_count_q, pending_count_d;

  logic            alu_gnt, lsu_gnt, xfer;
  logic [4:0]      xfer_rd;
  logic [XLEN-1:0] xfer_data;
  logic            issue_fire;

  // Arbitration: sole requester wins; on contention the pointer decides.
  always_comb begin
    alu_gnt   = AluValid & (~LsuValid | (ptr_q == PTR_ALU));
    lsu_gnt   = LsuValid & (~AluValid | (ptr_q == PTR_LSU));
    xfer      = alu_gnt | lsu_gnt;
    xfer_rd   = alu_gnt ? AluRd   : LsuRd;
    xfer_data = alu_gnt ? AluData : LsuData;
  end

  assign AluReady = alu_gnt;
  assign LsuReady = lsu_gnt;

  // Hazard check uses registered busy only; no same-cycle bypass from a
  // committing write, so a reader waits until the edge after the commit.
  assign IssueStall = IssueValid &
                      (busy_q[IssueRs1] | busy_q[IssueRs2] | busy_q[IssueRd]);
  // A flush cycle discards the issue even if it would have been accepted.
  assign issue_fire = IssueValid & ~IssueStall & ~Flush;

  // Next-state: busy vector (set wins over commit clear), pointer, WB port.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) busy_d[write_addr_q] = 1'b0;
    if (Flush) begin
      busy_d = '0;
    end else if (issue_fire && (IssueRd != 5'd0)) begin
      busy_d[IssueRd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    ptr_d = ptr_q;
    if (Flush) begin
      ptr_d = PTR_ALU;
    end else if (AluValid && LsuValid) begin
      ptr_d = (ptr_q == PTR_ALU) ? PTR_LSU : PTR_ALU;
    end

    // Rd=0 transfers are consumed but never reach the register file.
    reg_write_d  = xfer & (xfer_rd != 5'd0);
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (reg_write_d) begin
      write_addr_d = xfer_rd;
      write_data_d = xfer_data;
    end

    pending_count_d = '0;
    for (int i = 1; i < 32; i++) begin
      pending_count_d = pending_count_d + 6'(busy_d[i]);
    end
  end

  // State registers; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q          <= '0;
      ptr_q           <= PTR_ALU;
      reg_write_q     <= 1'b0;
      write_addr_q    <= '0;
      write_data_q    <= '0;
      pending_count_q <= '0;
    end else begin
      busy_q          <= busy_d;
      ptr_q           <= ptr_d;
      reg_write_q     <= reg_write_d;
      write_addr_q    <= write_addr_d;
      write_data_q    <= write_data_d;
      pending_count_q <= pending_count_d;
    end
  end

  assign RegWrite     = reg_write_q;
  assign WriteAddr    = write_addr_q;
  assign WriteData    = write_data_q;
  assign PendingCount = pending_count_q;

`ifdef WB_ERR_CHECK_EN
  logic wb_error_q, wb_error_d;

  // Sticky flag: a write-back arrived for a register nobody is waiting on.
  always_comb begin
    wb_error_d = wb_error_q |
                 (xfer & (xfer_rd != 5'd0) & ~busy_q[xfer_rd]);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_error_q <= 1'b0;
    else        wb_error_q <= wb_error_d;
  end

  assign WbError = wb_error_q;
`else
  assign WbError = 1'b0;
`endif

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data width of the write-back path.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port IssueValid, input, 1, an instruction requests issue this cycle.
REQ-005 SHALL have ports IssueRs1, IssueRs2, IssueRd, input, 5 each, the issuing instruction's source and destination registers.
REQ-006 SHALL have port IssueStall, output, 1, the issue cannot be accepted this cycle.
REQ-007 SHALL have ports AluValid, AluRd[4:0], AluData[XLEN-1:0] (input) and AluReady (output), the ALU write-back request channel.
REQ-008 SHALL have ports LsuValid, LsuRd[4:0], LsuData[XLEN-1:0] (input) and LsuReady (output), the load-unit write-back request channel.
REQ-009 SHALL have port Flush, input, 1, a synchronous scoreboard clear.
REQ-010 SHALL have ports RegWrite (1), WriteAddr (5) and WriteData (XLEN), outputs, which drive the register-file write port.
REQ-011 SHALL have port PendingCount, output, 6, the number of set busy bits.
REQ-012 SHALL have port WbError, output, 1, a sticky write-back protocol error (see Configuration).

Function
REQ-013 SHALL hold a 32-bit busy vector; bit 0 is hardwired to 0.
REQ-014 SHALL drive IssueStall = IssueValid & (busy[IssueRs1] | busy[IssueRs2] | busy[IssueRd]), combinational from registered busy only, with no same-cycle bypass.
REQ-015 SHALL accept an issue when IssueValid=1 and IssueStall=0, and set busy[IssueRd] at that edge if IssueRd!=0.
REQ-016 SHALL arbitrate ALU vs LSU round-robin: a sole requester is granted; when both request, the source holding the priority pointer is granted, and the pointer then moves to the other source.
REQ-017 SHALL assert AluReady/LsuReady combinationally only for the granted source; a transfer occurs when Valid & Ready; at most one transfer per cycle.
REQ-018 SHALL register an accepted transfer: on the next cycle RegWrite=1, WriteAddr=Rd and WriteData=Data, giving 1-cycle latency; otherwise RegWrite=0 and WriteAddr/WriteData hold their last values.
REQ-019 SHALL accept a transfer with Rd=0 but produce RegWrite=0 and no busy change.
REQ-020 SHALL clear busy[WriteAddr] at the edge where RegWrite=1 (the register-file commit edge), so the reads in the following cycle see new data.
REQ-021 SHALL let a set win when a set and a clear of the same bit occur on the same edge.
REQ-022 SHALL, when Flush=1, clear all busy bits and reset the pointer to ALU at the edge, ignore any issue that cycle, and still let an already registered RegWrite complete; Flush SHALL NOT block write-back acceptance.
REQ-023 SHALL register PendingCount as the popcount of the next-state busy vector, range 0..31.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force busy=0, RegWrite=0, WriteAddr=0, WriteData=0, pointer=ALU, PendingCount=0 and WbError=0.
REQ-025 SHALL, when reset asserts mid-transfer, drop the pending write; no RegWrite pulse follows deassertion.

Configuration
REQ-026 SHALL, with macro WB_ERR_CHECK_EN defined, set WbError (sticky until reset) when an accepted transfer has Rd!=0 and busy[Rd]=0.
REQ-027 SHALL, without WB_ERR_CHECK_EN, tie WbError to 0 and implement no check logic.

Verification
REQ-028 SHALL check: issue Rd=5 accepted, then issue Rs1=5 -> IssueStall=1 until the edge after ALU write-back of Rd=5 commits, then 0.
REQ-029 SHALL check: ALU and LSU both valid for 4 cycles from reset -> grants ALU, LSU, ALU, LSU; RegWrite asserted each following cycle with matching WriteAddr/WriteData.
REQ-030 SHALL check: LSU write-back Rd=0, Data=0xDEADBEEF -> LsuReady=1, RegWrite stays 0, PendingCount unchanged.
REQ-031 SHALL check: issue Rd=3, 7, 9, then Flush -> PendingCount 3 then 0; IssueRs1=7 no longer stalls.
REQ-032 SHALL check: with WB_ERR_CHECK_EN, ALU write-back to non-busy Rd=12 -> WbError=1 next cycle and held; without the macro, WbError=0.
REQ-033 SHALL check: assert rst_n=0 on the cycle after an accepted transfer -> RegWrite=0 immediately, busy=0, and no write after release.
